// File: rtl/adc_pkg.sv
// ----------------------------------------------------------------------------
// adc_pkg
// Shared constants, state type and helpers for the ADC128S022 emulator.
//   FRAME_BITS      : SCK falling edges per conversion frame
//   LEAD_ZEROS      : zero bits ahead of the 12-bit sample in the frame word
//   ADDR_FIRST_EDGE : falling-edge count at which the first address bit is taken
//   NUM_CH          : number of channel sample registers
// ----------------------------------------------------------------------------
package adc_pkg;

    localparam int FRAME_BITS      = 16;
    localparam int LEAD_ZEROS      = 4;
    localparam int ADDR_FIRST_EDGE = 3;
    localparam int NUM_CH          = 8;

    localparam int ADDR_W   = $clog2(NUM_CH);
    localparam int SAMPLE_W = FRAME_BITS - LEAD_ZEROS;
    localparam int CNT_W    = $clog2(FRAME_BITS);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Frame word as shifted out MSB first: leading zeros, then the sample.
    function automatic logic [FRAME_BITS-1:0] make_word(input logic [SAMPLE_W-1:0] sample);
        return {{LEAD_ZEROS{1'b0}}, sample};
    endfunction

endpackage

// File: rtl/adc128s022_emu_if.sv
// ----------------------------------------------------------------------------
// adc128s022_emu_if
// Serial pins between an ADC128S022 master and the emulator.
//   adc_cs_n : chip select, low = frame active      (master -> slave)
//   adc_sck  : serial clock, idles high              (master -> slave)
//   din      : channel address bits                  (master -> slave)
//   dout     : conversion word, MSB first            (slave -> master)
//   dout_oe  : pad tri-state enable for dout         (slave -> master)
// ----------------------------------------------------------------------------
interface adc128s022_emu_if;

    logic adc_cs_n;
    logic adc_sck;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (
        output adc_cs_n,
        output adc_sck,
        output din,
        input  dout,
        input  dout_oe
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sck,
        input  din,
        output dout,
        output dout_oe
    );

endinterface

// File: rtl/adc128s022_emu_sync_edge.sv
// ----------------------------------------------------------------------------
// sync_edge
// STAGES-deep synchronizer for an asynchronous pin followed by an edge
// register that yields single-cycle rise/fall pulses.
//   clk, rst_n : system clock, asynchronous active-low reset
//   async_in   : asynchronous input pin
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized edges
// Edges are suppressed until the chain and edge register hold real samples
// after reset, so a pin already away from IDLE_VAL at reset release does not
// look like an edge.
// ----------------------------------------------------------------------------
module sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              edge_q, edge_d;
    logic [STAGES:0]   prime_q, prime_d;

    assign sync_d[0] = async_in;
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
        assign sync_d[gi] = sync_q[gi-1];
    end

    always_comb begin
        edge_d  = sync_q[STAGES-1];
        prime_d = {prime_q[STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {STAGES{IDLE_VAL}};
            edge_q  <= IDLE_VAL;
            prime_q <= '0;
        end else begin
            sync_q  <= sync_d;
            edge_q  <= edge_d;
            prime_q <= prime_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = prime_q[STAGES] &  level & ~edge_q;
    assign fall  = prime_q[STAGES] & ~level &  edge_q;

endmodule

// File: rtl/adc128s022_emu.sv
// ----------------------------------------------------------------------------
// adc128s022_emu
// Slave-side emulation of a TI ADC128S022: eight writable 12-bit channel
// registers served over the ADC's 16-clock serial frame.
//   clk_50, rst_n                    : system clock, async active-low reset
//   spi (slave)                      : adc_cs_n/adc_sck/din in, dout/dout_oe out
//   ch_wr_en/ch_wr_addr/ch_wr_data   : channel register write port
//   frame_done                       : one-cycle pulse per completed frame
//   frame_err                        : one-cycle pulse on cs_n rise mid-frame
//   cur_addr                         : channel the next frame will output
// The address received in frame N selects the sample of frame N+1. While
// cs_n stays low, frames repeat back to back.
// ----------------------------------------------------------------------------
module adc128s022_emu
    import adc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_50,
    input  logic                 rst_n,
    adc128s022_emu_if.slave      spi,
    input  logic                 ch_wr_en,
    input  logic [ADDR_W-1:0]    ch_wr_addr,
    input  logic [SAMPLE_W-1:0]  ch_wr_data,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [ADDR_W-1:0]    cur_addr
);

    localparam logic [CNT_W-1:0] CNT_ADDR_LO = CNT_W'(ADDR_FIRST_EDGE);
    localparam logic [CNT_W-1:0] CNT_ADDR_HI = CNT_W'(ADDR_FIRST_EDGE + ADDR_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_BITS - 1);

    // ---------------- pin synchronizers ----------------
    logic sck_level, sck_rise, sck_fall;
    logic cs_level,  cs_rise,  cs_fall;
    logic din_level, din_rise, din_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_sck (
        .clk(clk_50), .rst_n(rst_n), .async_in(spi.adc_sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
        .clk(clk_50), .rst_n(rst_n), .async_in(spi.adc_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_din (
        .clk(clk_50), .rst_n(rst_n), .async_in(spi.din),
        .level(din_level), .rise(din_rise), .fall(din_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sck_level, cs_level, din_rise, din_fall};

    // ---------------- channel sample registers ----------------
    logic [NUM_CH-1:0][SAMPLE_W-1:0] ch_reg_q, ch_reg_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_reg_d[i] = ch_reg_q[i];
            if (ch_wr_en && (ch_wr_addr == ADDR_W'(i)))
                ch_reg_d[i] = ch_wr_data;
        end
    end

    // ---------------- frame FSM ----------------
    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        fall_cnt_q, fall_cnt_d;
    logic [FRAME_BITS-1:0]   frame_word_q, frame_word_d;
    logic [ADDR_W-1:0]       addr_sh_q, addr_sh_d;
    logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d;
    logic                    dout_q, dout_d;
    logic                    dout_oe_q, dout_oe_d;
    logic                    frame_done_q, frame_done_d;
    logic                    frame_err_q, frame_err_d;

    always_comb begin
        state_d      = state_q;
        fall_cnt_d   = fall_cnt_q;
        frame_word_d = frame_word_q;
        addr_sh_d    = addr_sh_q;
        cur_addr_d   = cur_addr_q;
        dout_oe_d    = dout_oe_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d      = ST_ACTIVE;
                    // Loads read ch_reg_q, so a same-cycle write is not seen.
                    frame_word_d = make_word(ch_reg_q[cur_addr_q]);
                    fall_cnt_d   = '0;
                    addr_sh_d    = '0;
                    dout_oe_d    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    dout_oe_d   = 1'b0;
                    fall_cnt_d  = '0;
                    addr_sh_d   = '0;
                    frame_err_d = (fall_cnt_q != '0);
                end else begin
                    // Address bits arrive MSB first on three consecutive rises.
                    if (sck_rise && (fall_cnt_q >= CNT_ADDR_LO) && (fall_cnt_q <= CNT_ADDR_HI))
                        addr_sh_d = {addr_sh_q[ADDR_W-2:0], din_level};
                    if (sck_fall) begin
                        if (fall_cnt_q == CNT_LAST) begin
                            frame_done_d = 1'b1;
                            cur_addr_d   = addr_sh_q;
                            fall_cnt_d   = '0;
                            frame_word_d = make_word(ch_reg_q[addr_sh_q]);
                            addr_sh_d    = '0;
                        end else begin
                            fall_cnt_d = fall_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        dout_d = (state_d == ST_ACTIVE) ? frame_word_d[CNT_LAST - fall_cnt_d] : 1'b0;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fall_cnt_q   <= '0;
            frame_word_q <= '0;
            addr_sh_q    <= '0;
            cur_addr_q   <= '0;
            dout_q       <= 1'b0;
            dout_oe_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ch_reg_q     <= '0;
        end else begin
            state_q      <= state_d;
            fall_cnt_q   <= fall_cnt_d;
            frame_word_q <= frame_word_d;
            addr_sh_q    <= addr_sh_d;
            cur_addr_q   <= cur_addr_d;
            dout_q       <= dout_d;
            dout_oe_q    <= dout_oe_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            ch_reg_q     <= ch_reg_d;
        end
    end

    assign spi.dout    = dout_q;
    assign spi.dout_oe = dout_oe_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign cur_addr    = cur_addr_q;

endmodule

// File: tb/tb_adc128s022_emu.sv
// ----------------------------------------------------------------------------
// tb_adc128s022_emu
// Drives the emulator as a 2.5 MHz ADC master with random phase to clk_50.
// Expected frame words come from a channel-array model: each frame returns
// the channel addressed by the previous completed frame, snapshotted at the
// frame's start.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc128s022_emu;

    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic        ch_wr_en;
    logic [2:0]  ch_wr_addr;
    logic [11:0] ch_wr_data;
    logic        frame_done;
    logic        frame_err;
    logic [2:0]  cur_addr;

    always #10 clk_50 = ~clk_50;

    adc128s022_emu_if spi();

    adc128s022_emu #(.SYNC_STAGES(2)) dut (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .spi        (spi.slave),
        .ch_wr_en   (ch_wr_en),
        .ch_wr_addr (ch_wr_addr),
        .ch_wr_data (ch_wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .cur_addr   (cur_addr)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] ch_m [8];
    logic [2:0]  cur_m;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    logic        done_prev = 1'b0;
    logic        err_prev  = 1'b0;
    bit          expect_idle   = 1'b0;
    bit          expect_active = 1'b0;
    time         last_chg = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle monitor ----------------
    always @(spi.dout) last_chg = $time;

    always @(negedge clk_50) begin
        if (frame_done) begin
            done_cnt++;
            check("done_pulse_width", done_prev, 0);
        end
        if (frame_err) begin
            err_cnt++;
            check("err_pulse_width", err_prev, 0);
        end
        done_prev = frame_done;
        err_prev  = frame_err;
        if (expect_idle) begin
            check("idle_dout_oe", spi.dout_oe, 0);
            check("idle_dout", spi.dout, 0);
        end
        if (expect_active)
            check("active_dout_oe", spi.dout_oe, 1);
    end

    // ---------------- master stimulus ----------------
    task automatic ch_write(input logic [2:0] a, input logic [11:0] d);
        @(negedge clk_50);
        ch_wr_en = 1'b1; ch_wr_addr = a; ch_wr_data = d;
        @(negedge clk_50);
        ch_wr_en = 1'b0;
        ch_m[a] = d;
        $display("write ch%0d = %h", a, d);
    endtask

    task automatic cs_low();
        #($urandom_range(0, 19));
        expect_idle = 1'b0;
        spi.adc_cs_n = 1'b0;
        #200;
        expect_active = 1'b1;
    endtask

    task automatic cs_high();
        expect_active = 1'b0;
        spi.adc_cs_n = 1'b1;
        #200;
        expect_idle = 1'b1;
        #200;
    endtask

    // Runs nfalls SCK periods; bits collects dout just before each fall.
    task automatic sck_run(input int nfalls, input logic [2:0] a0, input logic [2:0] a1,
                           output logic [31:0] bits);
        bits = '0;
        for (int k = 0; k < nfalls; k++) begin
            int p;
            logic [2:0] a;
            p = k % 16;
            a = (k < 16) ? a0 : a1;
            bits = {bits[30:0], spi.dout};
            spi.adc_sck = 1'b0;
            if (p >= 2 && p <= 4) spi.din = a[4-p];
            else                  spi.din = 1'($urandom_range(0, 1));
            #200;
            check("dout_setup_5clk", 32'(($time - last_chg) >= 100), 1);
            spi.adc_sck = 1'b1;
            #200;
        end
    endtask

    // One transaction: 1..15 falls = aborted frame, 16 = one frame, 32 = two.
    task automatic frame(input int nfalls, input logic [2:0] a0, input logic [2:0] a1,
                         input string tag, output logic [31:0] bits);
        logic [15:0] exp0, exp1;
        int d0, e0;
        exp0 = {4'h0, ch_m[cur_m]};
        d0 = done_cnt;
        e0 = err_cnt;
        cs_low();
        sck_run(nfalls, a0, a1, bits);
        cs_high();
        if (nfalls < 16) begin
            check({tag, "_partial"}, bits, 32'(exp0 >> (16 - nfalls)));
            check({tag, "_err_cnt"}, err_cnt - e0, 1);
            check({tag, "_done_cnt"}, done_cnt - d0, 0);
        end else if (nfalls == 16) begin
            check({tag, "_word"}, bits[15:0], exp0);
            cur_m = a0;
            check({tag, "_done_cnt"}, done_cnt - d0, 1);
            check({tag, "_err_cnt"}, err_cnt - e0, 0);
        end else begin
            check({tag, "_word0"}, bits[31:16], exp0);
            exp1 = {4'h0, ch_m[a0]};
            check({tag, "_word1"}, bits[15:0], exp1);
            cur_m = a1;
            check({tag, "_done_cnt"}, done_cnt - d0, 2);
            check({tag, "_err_cnt"}, err_cnt - e0, 0);
        end
        check({tag, "_cur_addr"}, cur_addr, cur_m);
        $display("frame %s falls=%0d addr=%0d/%0d bits=%h cur_addr=%0d", tag, nfalls, a0, a1,
                 bits, cur_addr);
    endtask

    initial begin
        logic [31:0] b;
        int d_start;
        rst_n = 1'b0;
        spi.adc_cs_n = 1'b1; spi.adc_sck = 1'b1; spi.din = 1'b0;
        ch_wr_en = 1'b0; ch_wr_addr = '0; ch_wr_data = '0;
        for (int i = 0; i < 8; i++) ch_m[i] = '0;
        cur_m = '0;
        #5;
        check("rst_dout", spi.dout, 0);
        check("rst_dout_oe", spi.dout_oe, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_cur_addr", cur_addr, 0);
        #100;
        @(negedge clk_50);
        rst_n = 1'b1;
        #100;
        expect_idle = 1'b1;

        // Pipelined addressing: frame 1 returns ch0, frame 2 returns ch5.
        ch_write(3'd5, 12'hA5C);
        d_start = done_cnt;
        frame(16, 3'd5, 3'd0, "f1", b);
        check("f1_literal", b[15:0], 16'h0000);
        check("f1_cur_addr_lit", cur_addr, 3'd5);
        frame(16, 3'd2, 3'd0, "f2", b);
        check("f2_literal", b[15:0], 16'h0A5C);
        check("f12_done_lit", done_cnt - d_start, 2);

        // Continuous mode: 32 SCK with cs_n low.
        ch_write(3'd6, 12'h123);
        frame(32, 3'd6, 3'd7, "cont", b);
        check("cont_literal", b[15:0], 16'h0123);

        // Abort after 8 falls, then a clean frame.
        ch_write(3'd7, 12'h3C9);
        frame(8, 3'd3, 3'd0, "abort", b);
        check("abort_cur_addr_lit", cur_addr, 3'd7);
        frame(16, 3'd1, 3'd0, "after_abort", b);
        check("after_abort_lit", b[15:0], 16'h03C9);

        // Write to the channel being shifted out mid-frame.
        ch_write(3'd5, 12'h001);
        frame(16, 3'd5, 3'd0, "pre_wr", b);
        fork
            frame(16, 3'd5, 3'd0, "mid_wr", b);
            begin
                #3000;
                ch_write(3'd5, 12'hFFF);
            end
        join
        check("mid_wr_literal", b[15:0], 16'h0001);
        frame(16, 3'd0, 3'd0, "post_wr", b);
        check("post_wr_literal", b[15:0], 16'h0FFF);

        // Randomized traffic.
        for (int it = 0; it < 20; it++) begin
            int mode;
            ch_write(3'($urandom_range(0, 7)), 12'($urandom));
            mode = $urandom_range(0, 3);
            if (mode == 0)
                frame($urandom_range(1, 15), 3'($urandom_range(0, 7)), 3'd0, "rnd_abort", b);
            else if (mode == 1)
                frame(32, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rnd_cont", b);
            else
                frame(16, 3'($urandom_range(0, 7)), 3'd0, "rnd", b);
        end

        // Reset in the middle of a frame (fall_cnt = 10).
        cs_low();
        sck_run(10, 3'd4, 3'd0, b);
        expect_active = 1'b0;
        rst_n = 1'b0;
        expect_idle = 1'b1;
        #1;
        check("midrst_dout", spi.dout, 0);
        check("midrst_dout_oe", spi.dout_oe, 0);
        check("midrst_cur_addr", cur_addr, 0);
        for (int i = 0; i < 8; i++) ch_m[i] = '0;
        cur_m = '0;
        #100;
        @(negedge clk_50);
        rst_n = 1'b1;
        d_start = done_cnt;
        sck_run(16, 3'd4, 3'd0, b);
        check("norestart_done", done_cnt - d_start, 0);
        check("norestart_bits", b, 0);
        cs_high();
        frame(16, 3'd3, 3'd0, "post_rst", b);
        check("post_rst_literal", b[15:0], 16'h0000);
        check("post_rst_cur_addr_lit", cur_addr, 3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
